// File: rtl/pll_lock_sequencer.sv
// Power-up sequencer for the core PLL: synchronises and filters the locked flag,
// pulses the PLL reset with a retry watchdog, and releases the core system reset.
module pll_lock_sequencer #(
  parameter int SYNC_STAGES  = 2,
  parameter int PLL_RST_CYC  = 16,
  parameter int FILTER_CYC   = 64,
  parameter int LOCK_TIMEOUT = 500000,
  parameter int HOLD_CYC     = 1024,
  parameter int CNT_W        = 8
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_reset,
  output logic             ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] loss_cnt,
  output logic [CNT_W-1:0] timeout_cnt
);

  localparam logic [1:0] S_PLLRST = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_HOLD   = 2'd2;
  localparam logic [1:0] S_RUN    = 2'd3;

  localparam int MAX_AB = (PLL_RST_CYC > LOCK_TIMEOUT) ? PLL_RST_CYC : LOCK_TIMEOUT;
  localparam int MAX_C  = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
  localparam int CW     = $clog2(MAX_C + 1);
  localparam int FW     = $clog2(FILTER_CYC + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   locked_s;
  logic [CW-1:0]          cnt;
  logic [FW-1:0]          filt;
  logic [1:0]             next_state;
  logic                   state_change;
  logic                   timeout_evt;
  logic                   loss_evt;

  assign locked_s = sync[SYNC_STAGES-1];

  // Lock acceptance is checked before the watchdog so a simultaneous hit favours lock.
  always_comb begin
    next_state = state;
    case (state)
      S_PLLRST: if (cnt == CW'(PLL_RST_CYC - 1)) next_state = S_WAIT;
      S_WAIT: begin
        if (locked_s && (filt == FW'(FILTER_CYC - 1))) next_state = S_HOLD;
        else if (cnt == CW'(LOCK_TIMEOUT - 1))         next_state = S_PLLRST;
      end
      S_HOLD: begin
        if (!locked_s)                         next_state = S_WAIT;
        else if (cnt == CW'(HOLD_CYC - 1))     next_state = S_RUN;
      end
      default: if (!locked_s) next_state = S_WAIT;
    endcase
  end

  assign state_change = (next_state != state);
  assign timeout_evt  = (state == S_WAIT) && (next_state == S_PLLRST);
  assign loss_evt     = ((state == S_HOLD) || (state == S_RUN)) && (next_state == S_WAIT);

  // Outputs are registered from next_state so they always agree with the state register.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sync        <= '0;
      state       <= S_PLLRST;
      cnt         <= '0;
      filt        <= '0;
      pll_rst     <= 1'b1;
      sys_reset   <= 1'b1;
      ready       <= 1'b0;
      loss_cnt    <= '0;
      timeout_cnt <= '0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], pll_locked};
      state     <= next_state;
      pll_rst   <= (next_state == S_PLLRST);
      sys_reset <= (next_state != S_RUN);
      ready     <= (state == S_HOLD) && (next_state == S_RUN);

      // RUN has no timed exit, so the shared counter parks there instead of wrapping.
      if (state_change)        cnt <= '0;
      else if (state != S_RUN) cnt <= cnt + 1'b1;

      if (state_change || (state != S_WAIT) || !locked_s) filt <= '0;
      else                                                filt <= filt + 1'b1;

      if (loss_evt && (loss_cnt != {CNT_W{1'b1}}))       loss_cnt    <= loss_cnt + 1'b1;
      if (timeout_evt && (timeout_cnt != {CNT_W{1'b1}})) timeout_cnt <= timeout_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed and random checks of pll_lock_sequencer against a cycle-level reference
// model built from the sequencing rules (delay queue, cycles-in-state, high-run length).
module tb_pll_lock_sequencer;

  localparam int SYNC  = 2;
  localparam int PRST  = 4;
  localparam int FILT  = 3;
  localparam int TMO   = 20;
  localparam int HOLDC = 5;
  localparam int CW    = 2;
  localparam int SAT   = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pll_locked = 1'b0;
  logic          pll_rst;
  logic          sys_reset;
  logic          ready;
  logic [1:0]    state;
  logic [CW-1:0] loss_cnt;
  logic [CW-1:0] timeout_cnt;

  pll_lock_sequencer #(
    .SYNC_STAGES(SYNC), .PLL_RST_CYC(PRST), .FILTER_CYC(FILT),
    .LOCK_TIMEOUT(TMO), .HOLD_CYC(HOLDC), .CNT_W(CW)
  ) dut (
    .clk_sys(clk), .reset(reset), .pll_locked(pll_locked),
    .pll_rst(pll_rst), .sys_reset(sys_reset), .ready(ready), .state(state),
    .loss_cnt(loss_cnt), .timeout_cnt(timeout_cnt)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: 0=PLLRST 1=WAIT 2=HOLD 3=RUN
  int m_state, m_time, m_run, m_loss, m_tmo;
  bit m_ready;
  bit dly_q[$];
  int ready_pulses;
  bit saw_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit ls;
    int nxt;
    if (reset) begin
      m_state = 0; m_time = 0; m_run = 0; m_loss = 0; m_tmo = 0; m_ready = 0;
      dly_q = {};
      repeat (SYNC) dly_q.push_back(1'b0);
      return;
    end
    ls = dly_q.pop_back();
    dly_q.push_front(pll_locked);
    nxt = m_state;
    m_ready = 0;
    case (m_state)
      0: if (m_time + 1 == PRST) nxt = 1;
      1: begin
        m_run = ls ? m_run + 1 : 0;
        if (m_run == FILT) nxt = 2;
        else if (m_time + 1 == TMO) begin
          nxt = 0;
          if (m_tmo < SAT) m_tmo++;
        end
      end
      2: begin
        if (!ls) begin
          nxt = 1;
          if (m_loss < SAT) m_loss++;
        end else if (m_time + 1 == HOLDC) begin
          nxt = 3;
          m_ready = 1;
        end
      end
      default: if (!ls) begin
        nxt = 1;
        if (m_loss < SAT) m_loss++;
      end
    endcase
    if (nxt != m_state) begin
      m_time = 0;
      m_run = 0;
    end else begin
      m_time++;
    end
    m_state = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("state", state, m_state);
    chk("pll_rst", pll_rst, (m_state == 0));
    chk("sys_reset", sys_reset, (m_state != 3));
    chk("ready", ready, m_ready);
    chk("loss_cnt", loss_cnt, m_loss);
    chk("timeout_cnt", timeout_cnt, m_tmo);
    if (ready === 1'b1) ready_pulses++;
    if (state === 2'd2) saw_hold = 1;
  endtask

  task automatic wait_state(input int st, input int budget);
    int n = 0;
    while (state !== st[1:0] && n < budget) begin
      tick();
      n++;
    end
    chk("wait_state", state, st);
  endtask

  initial begin
    // reset and first lock
    reset = 1'b1; pll_locked = 1'b0;
    tick(); tick();
    chk("reset_state", state, 0);
    chk("reset_pll_rst", pll_rst, 1);
    reset = 1'b0;
    ready_pulses = 0;
    tick(); tick();
    pll_locked = 1'b1;
    wait_state(3, 60);
    chk("s1_ready_pulses", ready_pulses, 1);
    chk("s1_sys_reset", sys_reset, 0);

    // one-cycle lock drop in RUN
    ready_pulses = 0;
    pll_locked = 1'b0; tick();
    pll_locked = 1'b1;
    repeat (4) tick();
    chk("s4_state", state, 1);
    chk("s4_loss", loss_cnt, 1);
    chk("s4_sys_reset", sys_reset, 1);
    chk("s4_no_ready", ready_pulses, 0);
    wait_state(3, 60);
    chk("s4_relock_ready", ready_pulses, 1);

    // lock drop early in HOLD
    pll_locked = 1'b0; tick();
    pll_locked = 1'b1;
    wait_state(2, 60);
    ready_pulses = 0;
    tick();
    pll_locked = 1'b0; tick();
    pll_locked = 1'b1;
    repeat (3) tick();
    chk("s5_state", state, 1);
    chk("s5_loss", loss_cnt, 3);
    chk("s5_no_ready", ready_pulses, 0);

    // reset pulse while running
    wait_state(3, 80);
    reset = 1'b1; tick();
    reset = 1'b0;
    chk("s6_state", state, 0);
    chk("s6_pll_rst", pll_rst, 1);
    chk("s6_sys_reset", sys_reset, 1);
    chk("s6_loss", loss_cnt, 0);
    chk("s6_tmo", timeout_cnt, 0);

    // no lock: watchdog retries every PRST+TMO cycles, counter saturates
    pll_locked = 1'b0;
    repeat (30) tick();
    chk("s2_tmo_first", timeout_cnt, 1);
    repeat (70) tick();
    chk("s2_tmo_sat", timeout_cnt, 3);

    // single-cycle glitches never satisfy the filter
    saw_hold = 0;
    repeat (20) begin
      pll_locked = 1'b1; tick();
      pll_locked = 1'b0;
      repeat ($urandom_range(1, 3)) tick();
    end
    chk("s3_no_hold", saw_hold, 0);

    // random lock bursts with occasional reset
    repeat (60) begin
      int len;
      len = $urandom_range(1, 30);
      pll_locked = ($urandom_range(0, 99) < 70);
      reset = ($urandom_range(0, 99) < 5);
      tick();
      reset = 1'b0;
      repeat (len) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
